mult_div_unit: RTL and testbench

- Iterative signed multiply/divide datapath that sits directly downstream of the multicycle control unit.
- Consumes the control unit's MDControl selection and a start strobe, with operands taken from registers A/B.
- Produces 2*WIDTH-bit results that the control unit commits to architectural HI/LO via WriteHI/WriteLO once done pulses.
- Raises div0 for divide-by-zero so the control unit can take the exception path.

---
 rtl/mult_div_unit.sv | 144 ++++++++++++++
 tb/tb_mult_div_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and restoring divide.
// One step per cycle for WIDTH cycles; hi/lo update only on completion.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resert,
    input  logic             start,
    input  logic             MDControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_MULT, S_DIV, S_FIN, S_DZERO
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             q1;
    logic [WIDTH-1:0] opr;
    logic             neg_q, neg_r;

    logic [WIDTH:0]     m_ext, sum;
    logic [2*WIDTH+1:0] sh;
    logic [WIDTH:0]     shifted, diff;
    logic [WIDTH:0]     acc_n;
    logic [WIDTH-1:0]   q_n, rem_n, res_hi, res_lo;
    logic               q1_n;

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (resert) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (!MDControl)    state_n = S_MULT;
                    else if (b != '0)  state_n = S_DIV;
                    else               state_n = S_DZERO;
                end
            end
            S_MULT, S_DIV: if (last) state_n = S_FIN;
            S_FIN, S_DZERO: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_MULT) || (state == S_DIV);
        done = (state == S_FIN);
        div0 = (state == S_DZERO);
    end

    // Booth step: add/sub multiplicand by {q[0],q1}, then arithmetic shift
    always_comb begin
        m_ext = {opr[WIDTH-1], opr};
        unique case ({q[0], q1})
            2'b01:   sum = acc + m_ext;
            2'b10:   sum = acc - m_ext;
            default: sum = acc;
        endcase
        sh = {sum[WIDTH], sum, q};

        // Restoring step: remainder < divisor keeps diff within WIDTH+1 bits
        shifted = {acc[WIDTH-1:0], q[WIDTH-1]};
        diff    = shifted - {1'b0, opr};
        rem_n   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

        if (state == S_DIV) begin
            acc_n  = {1'b0, rem_n};
            q_n    = {q[WIDTH-2:0], ~diff[WIDTH]};
            q1_n   = 1'b0;
            res_lo = neg_q ? ('0 - q_n) : q_n;
            res_hi = neg_r ? ('0 - rem_n) : rem_n;
        end else begin
            acc_n  = sh[2*WIDTH+1:WIDTH+1];
            q_n    = sh[WIDTH:1];
            q1_n   = sh[0];
            res_lo = q_n;
            res_hi = acc_n[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (resert) begin
            cnt   <= '0;
            acc   <= '0;
            q     <= '0;
            q1    <= 1'b0;
            opr   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        acc <= '0;
                        q1  <= 1'b0;
                        if (!MDControl) begin
                            q   <= b;
                            opr <= a;
                        end else begin
                            q     <= a[WIDTH-1] ? ('0 - a) : a;
                            opr   <= b[WIDTH-1] ? ('0 - b) : b;
                            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_r <= a[WIDTH-1];
                        end
                    end
                end
                S_MULT, S_DIV: begin
                    acc <= acc_n;
                    q   <= q_n;
                    q1  <= q1_n;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit against a plain-arithmetic model.
// Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_mult_div_unit;

    logic        clk = 0;
    logic        resert;
    logic        start;
    logic        MDControl;
    logic [31:0] a, b;
    logic        busy, done, div0;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_hi = 0;
    logic [31:0] last_lo = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .resert(resert), .start(start), .MDControl(MDControl),
        .a(a), .b(b), .busy(busy), .done(done), .div0(div0),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Reference model: 64-bit signed arithmetic, truncating division
    task automatic model(input bit md, input logic [31:0] x,
                         input logic [31:0] y, output exp_t e);
        longint sx, sy, p, qq, rr;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.dz = 0;
        if (!md) begin
            p = sx * sy;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (y == 0) begin
            e.dz = 1;
            e.hi = last_hi;
            e.lo = last_lo;
        end else begin
            qq = sx / sy;
            rr = sx % sy;
            e.hi = rr[31:0];
            e.lo = qq[31:0];
        end
        if (!e.dz) begin
            last_hi = e.hi;
            last_lo = e.lo;
        end
    endtask

    always @(negedge clk) begin
        if (!resert) begin
            if (done && div0) chk("done_div0_overlap", 1, 0);
            if (done || div0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", {done, div0}, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("kind_div0", div0, e.dz);
                    chk("hi", hi, e.hi);
                    chk("lo", lo, e.lo);
                end
            end
        end
    end

    // Issue one op in IDLE; returns in the next IDLE cycle
    task automatic issue(input bit md, input logic [31:0] x,
                         input logic [31:0] y, input bit noise);
        exp_t e;
        int   n, nbusy;
        bit   hit;
        model(md, x, y, e);
        sb.push_back(e);
        start = 1; MDControl = md; a = x; b = y;
        @(posedge clk); #1;
        start = 0;
        n = 1; nbusy = 0; hit = 0;
        while (n <= 40) begin
            if (done || div0) begin
                hit = 1;
                break;
            end
            if (busy) nbusy++;
            a = $urandom; b = $urandom; MDControl = 1'($urandom);
            start = noise && (n == 5);
            @(posedge clk); #1;
            start = 0;
            n++;
        end
        chk("completed", hit, 1);
        chk("latency", n, e.dz ? 1 : 33);
        chk("busy_cycles", nbusy, e.dz ? 0 : 32);
        if (noise) start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("idle_after", {busy, done, div0}, 0);
        if (noise) begin
            int dn = 0;
            repeat (40) begin
                if (done || busy) dn++;
                @(posedge clk); #1;
            end
            chk("no_second_op", dn, 0);
        end
    endtask

    initial begin
        resert = 1; start = 0; MDControl = 0; a = 0; b = 0;
        repeat (3) @(posedge clk);
        #1 resert = 0;
        chk("reset_state", {busy, done, div0, hi, lo}, 0);

        issue(0, 32'd7, -32'sd3, 0);
        issue(0, 32'h8000_0000, 32'h8000_0000, 0);
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(1, -32'sd7, 32'd2, 0);
        issue(1, 32'd7, -32'sd2, 0);
        issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(1, 32'd68, 32'd7, 0);
        issue(1, 32'd123, 32'd0, 0);
        issue(0, 32'd3, 32'd4, 0);

        // Abort a multiply at iteration 10
        start = 1; MDControl = 0; a = 32'd1234; b = 32'd5678;
        @(posedge clk); #1;
        start = 0;
        repeat (10) @(posedge clk);
        #1 resert = 1;
        @(posedge clk); #1;
        resert = 0;
        chk("abort_state", {busy, done, div0, hi, lo}, 0);
        last_hi = 0; last_lo = 0;

        issue(0, 32'hDEAD_BEEF, 32'h1234_5678, 1);
        issue(1, 32'hDEAD_BEEF, 32'h0000_0000, 0);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] x, y;
            bit md;
            md = 1'($urandom);
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 0;
                1: y = 32'($urandom_range(0, 15)) - 32'd8;
                2: x = 32'h8000_0000;
                default: ;
            endcase
            issue(md, x, y, 0);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
